adc_spi_capture: RTL

- Serial-ADC front end sitting directly upstream of speckle_sensor_controller.
- Accepts the controller's o_adc_trigger and runs one SPI read frame on a 12-bit serial ADC (AD7476-style: 16-bit frame, 4 leading zeros, MSB first).
- Returns the sample on o_adc_val / o_adc_done, which connect directly to the controller's i_adc_val / i_adc_done.
- SCLK rate is set at run time by a clock-divider input.

---
 rtl/adc_spi_capture.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/adc_spi_capture.sv
// Serial-ADC capture front end.
// Runs one SPI read frame on an AD7476-style 12-bit ADC per accepted trigger
// and hands the sample back as a registered value with a done level, a
// one-clock valid pulse, and a frame-error pulse for nonzero leading bits.
module adc_spi_capture #(
  parameter int NB_DATA      = 12,
  parameter int NB_FRAME     = 16,
  parameter int NB_DIV       = 8,
  parameter int QUIET_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_trigger,
  input  logic [NB_DIV-1:0]  i_clk_div,
  input  logic               i_sdata,
  output logic               o_sclk,
  output logic               o_cs_n,
  output logic [NB_DATA-1:0] o_adc_val,
  output logic               o_adc_done,
  output logic               o_valid,
  output logic               o_frame_err
);

  localparam int NB_BIT   = (NB_FRAME > 2) ? $clog2(NB_FRAME) : 1;
  localparam int NB_QUIET = (QUIET_CYCLES > 2) ? $clog2(QUIET_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    QUIET
  } state_t;

  state_t               r_state,     w_state;
  logic [NB_DIV-1:0]    r_div,       w_div;
  logic [NB_DIV-1:0]    r_divCnt,    w_divCnt;
  logic [NB_BIT-1:0]    r_bitCnt,    w_bitCnt;
  logic                 r_phaseHigh, w_phaseHigh;
  logic [NB_FRAME-1:0]  r_shiftReg,  w_shiftReg;
  logic [NB_DATA-1:0]   r_result,    w_result;
  logic                 r_flag,      w_flag;
  logic [NB_QUIET-1:0]  r_quietCnt,  w_quietCnt;
  logic                 r_sclk,      w_sclk;
  logic                 r_csN,       w_csN;
  logic [NB_DATA-1:0]   r_adcVal,    w_adcVal;
  logic                 r_done,      w_done;
  logic                 r_valid,     w_valid;
  logic                 r_frameErr,  w_frameErr;

  logic                 w_divLast;
  logic [NB_FRAME-1:0]  w_leadBits;

  assign w_divLast  = (r_divCnt == (r_div - NB_DIV'(1)));
  // Everything above the data field is a leading bit that must read zero.
  assign w_leadBits = r_shiftReg >> NB_DATA;

  // Next-state and next-output logic; every register holds unless a state acts on it.
  always_comb begin
    w_state     = r_state;
    w_div       = r_div;
    w_divCnt    = r_divCnt;
    w_bitCnt    = r_bitCnt;
    w_phaseHigh = r_phaseHigh;
    w_shiftReg  = r_shiftReg;
    w_result    = r_result;
    w_flag      = r_flag;
    w_quietCnt  = r_quietCnt;
    w_sclk      = r_sclk;
    w_csN       = r_csN;
    w_adcVal    = r_adcVal;
    w_done      = r_done;
    w_valid     = 1'b0;
    w_frameErr  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_trigger) begin
          w_div    = (i_clk_div == '0) ? NB_DIV'(1) : i_clk_div;
          w_divCnt = '0;
          w_bitCnt = '0;
          w_sclk   = 1'b1;
          w_csN    = 1'b0;
          w_done   = 1'b0;
          w_state  = CS_SETUP;
        end
      end
      CS_SETUP: begin
        if (w_divLast) begin
          w_divCnt    = '0;
          w_sclk      = 1'b0;
          w_phaseHigh = 1'b0;
          w_state     = SHIFT;
        end else begin
          w_divCnt = r_divCnt + NB_DIV'(1);
        end
      end
      SHIFT: begin
        if (w_divLast) begin
          w_divCnt = '0;
          if (!r_phaseHigh) begin
            w_sclk      = 1'b1;
            w_phaseHigh = 1'b1;
            w_shiftReg  = {r_shiftReg[NB_FRAME-2:0], i_sdata};
          end else if (r_bitCnt == NB_BIT'(NB_FRAME - 1)) begin
            w_state = CS_HOLD;
          end else begin
            w_bitCnt    = r_bitCnt + NB_BIT'(1);
            w_sclk      = 1'b0;
            w_phaseHigh = 1'b0;
          end
        end else begin
          w_divCnt = r_divCnt + NB_DIV'(1);
        end
      end
      CS_HOLD: begin
        if (w_divLast) begin
          w_divCnt   = '0;
          w_csN      = 1'b1;
          w_result   = r_shiftReg[NB_DATA-1:0];
          w_flag     = |w_leadBits;
          w_quietCnt = '0;
          w_state    = QUIET;
        end else begin
          w_divCnt = r_divCnt + NB_DIV'(1);
        end
      end
      QUIET: begin
        if (r_quietCnt == NB_QUIET'(QUIET_CYCLES - 1)) begin
          w_adcVal   = r_result;
          w_done     = 1'b1;
          w_valid    = 1'b1;
          w_frameErr = r_flag;
          w_state    = IDLE;
        end else begin
          w_quietCnt = r_quietCnt + NB_QUIET'(1);
        end
      end
      default: begin
        w_state = IDLE;
        w_sclk  = 1'b1;
        w_csN   = 1'b1;
        w_done  = 1'b1;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_div       <= NB_DIV'(1);
      r_divCnt    <= '0;
      r_bitCnt    <= '0;
      r_phaseHigh <= 1'b0;
      r_shiftReg  <= '0;
      r_result    <= '0;
      r_flag      <= 1'b0;
      r_quietCnt  <= '0;
      r_sclk      <= 1'b1;
      r_csN       <= 1'b1;
      r_adcVal    <= '0;
      r_done      <= 1'b1;
      r_valid     <= 1'b0;
      r_frameErr  <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_div       <= w_div;
      r_divCnt    <= w_divCnt;
      r_bitCnt    <= w_bitCnt;
      r_phaseHigh <= w_phaseHigh;
      r_shiftReg  <= w_shiftReg;
      r_result    <= w_result;
      r_flag      <= w_flag;
      r_quietCnt  <= w_quietCnt;
      r_sclk      <= w_sclk;
      r_csN       <= w_csN;
      r_adcVal    <= w_adcVal;
      r_done      <= w_done;
      r_valid     <= w_valid;
      r_frameErr  <= w_frameErr;
    end
  end

  assign o_sclk      = r_sclk;
  assign o_cs_n      = r_csN;
  assign o_adc_val   = r_adcVal;
  assign o_adc_done  = r_done;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frameErr;

endmodule
